// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: word and RAM byte widths,
// boolean helpers, controller state encoding and an address helper.
package mem_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int RAM_WIDTH  = 8;
  localparam int WORD_BYTES = DATA_WIDTH / RAM_WIDTH;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Instruction fetches always move a whole word.
  localparam logic [2:0] IF_BYTES = 3'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IF_READ   = 2'd1,
    LSB_READ  = 2'd2,
    LSB_WRITE = 2'd3
  } state_t;

  // Address of byte k of a transfer; wraps naturally at 2^32.
  function automatic logic [DATA_WIDTH-1:0] byte_addr(input logic [DATA_WIDTH-1:0] base,
                                                      input logic [2:0]            k);
    return base + {{(DATA_WIDTH-3){1'b0}}, k};
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port and a
// load/store port onto a single 8-bit RAM with one-cycle read latency.
// Requests are latched into one pending slot per port; IDLE prefers the
// load/store slot. Build option MEM_CTRL_LSB_PORT_EN enables the load/store
// port; without it the LSB inputs are ignored and its outputs are tied low.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_flush,
  input  logic                  in_if_ena,
  input  logic [DATA_WIDTH-1:0] in_if_addr,
  output logic                  out_if_ready,
  output logic [DATA_WIDTH-1:0] out_if_inst,
  input  logic                  in_lsb_ena,
  input  logic                  in_lsb_rw,
  input  logic [2:0]            in_lsb_size,
  input  logic [DATA_WIDTH-1:0] in_lsb_addr,
  input  logic [DATA_WIDTH-1:0] in_lsb_data,
  output logic                  out_lsb_ready,
  output logic [DATA_WIDTH-1:0] out_lsb_data,
  output logic [DATA_WIDTH-1:0] out_ram_addr,
  output logic                  out_ram_rw,
  output logic [RAM_WIDTH-1:0]  out_ram_data,
  input  logic [RAM_WIDTH-1:0]  in_ram_data
);

  state_t                state_reg, state_next;
  logic [2:0]            cyc_reg, cyc_next;
  logic [2:0]            len_reg, len_next;
  logic [DATA_WIDTH-1:0] base_reg, base_next;
  logic [DATA_WIDTH-1:0] asm_reg, asm_next, asm_merged;
  logic                  if_pend_reg, if_pend_next;
  logic [DATA_WIDTH-1:0] if_addr_reg, if_addr_next;
  logic                  if_ready_reg, if_ready_next;
  logic [DATA_WIDTH-1:0] if_inst_reg, if_inst_next;
  logic [DATA_WIDTH-1:0] prev_addr_reg, ram_addr_live;
  logic [1:0]            cap_idx;

`ifdef MEM_CTRL_LSB_PORT_EN
  logic                  lsb_pend_reg, lsb_pend_next;
  logic                  lsb_rw_reg, lsb_rw_next;
  logic [2:0]            lsb_size_reg, lsb_size_next;
  logic [DATA_WIDTH-1:0] lsb_addr_reg, lsb_addr_next;
  logic [DATA_WIDTH-1:0] lsb_wdata_reg, lsb_wdata_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  lsb_ready_reg, lsb_ready_next;
  logic [DATA_WIDTH-1:0] lsb_data_reg, lsb_data_next;
`else
  logic                  unused_lsb;
  assign unused_lsb = ^{in_lsb_ena, in_lsb_rw, in_lsb_size, in_lsb_addr, in_lsb_data};
`endif

  // Byte returned by the RAM this cycle belongs to the address issued last cycle.
  assign cap_idx = cyc_reg[1:0] - 2'd1;

  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign asm_merged[gi*RAM_WIDTH +: RAM_WIDTH] =
        (cap_idx == 2'(gi)) ? in_ram_data : asm_reg[gi*RAM_WIDTH +: RAM_WIDTH];
    end
  endgenerate

  // While frozen, re-issue last cycle's address so the RAM keeps returning the
  // byte the stalled capture is waiting for.
  assign ram_addr_live = (state_reg == IDLE) ? '0 : byte_addr(base_reg, cyc_reg);
  assign out_ram_addr  = ena ? ram_addr_live : prev_addr_reg;
  assign out_if_ready  = if_ready_reg;
  assign out_if_inst   = if_inst_reg;

`ifdef MEM_CTRL_LSB_PORT_EN
  assign out_ram_rw    = ena && (state_reg == LSB_WRITE);
  assign out_ram_data  = out_ram_rw ? wdata_reg[{cyc_reg[1:0], 3'b000} +: RAM_WIDTH] : '0;
  assign out_lsb_ready = lsb_ready_reg;
  assign out_lsb_data  = lsb_data_reg;
`else
  assign out_ram_rw    = FALSE;
  assign out_ram_data  = '0;
  assign out_lsb_ready = FALSE;
  assign out_lsb_data  = '0;
`endif

  // Next-state, pending-slot capture, byte assembly and completion pulses
  always_comb begin
    state_next    = state_reg;
    cyc_next      = cyc_reg;
    len_next      = len_reg;
    base_next     = base_reg;
    asm_next      = asm_reg;
    if_pend_next  = if_pend_reg;
    if_addr_next  = if_addr_reg;
    if_ready_next = FALSE;
    if_inst_next  = if_inst_reg;
`ifdef MEM_CTRL_LSB_PORT_EN
    lsb_pend_next  = lsb_pend_reg;
    lsb_rw_next    = lsb_rw_reg;
    lsb_size_next  = lsb_size_reg;
    lsb_addr_next  = lsb_addr_reg;
    lsb_wdata_next = lsb_wdata_reg;
    wdata_next     = wdata_reg;
    lsb_ready_next = FALSE;
    lsb_data_next  = lsb_data_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef MEM_CTRL_LSB_PORT_EN
        if (lsb_pend_reg) begin
          state_next    = lsb_rw_reg ? LSB_WRITE : LSB_READ;
          base_next     = lsb_addr_reg;
          len_next      = lsb_size_reg;
          wdata_next    = lsb_wdata_reg;
          cyc_next      = '0;
          asm_next      = '0;
          lsb_pend_next = FALSE;
        end else
`endif
        if (if_pend_reg && !in_flush) begin
          state_next   = IF_READ;
          base_next    = if_addr_reg;
          len_next     = IF_BYTES;
          cyc_next     = '0;
          asm_next     = '0;
          if_pend_next = FALSE;
        end
      end
      IF_READ: begin
        cyc_next = cyc_reg + 3'd1;
        if (cyc_reg != 3'd0) asm_next = asm_merged;
        if (cyc_reg == len_reg) begin
          state_next    = IDLE;
          if_ready_next = TRUE;
          if_inst_next  = asm_merged;
        end
      end
`ifdef MEM_CTRL_LSB_PORT_EN
      LSB_READ: begin
        cyc_next = cyc_reg + 3'd1;
        if (cyc_reg != 3'd0) asm_next = asm_merged;
        if (cyc_reg == len_reg) begin
          state_next     = IDLE;
          lsb_ready_next = TRUE;
          lsb_data_next  = asm_merged;
        end
      end
      LSB_WRITE: begin
        cyc_next = cyc_reg + 3'd1;
        if (cyc_reg == len_reg - 3'd1) begin
          state_next     = IDLE;
          lsb_ready_next = TRUE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    // Flush kills the fetch path only; a same-cycle fetch pulse survives below.
    if (in_flush) begin
      if_pend_next = FALSE;
      if (state_reg == IF_READ) begin
        state_next    = IDLE;
        if_ready_next = FALSE;
        if_inst_next  = if_inst_reg;
      end
    end

    if (in_if_ena) begin
      if_pend_next = TRUE;
      if_addr_next = in_if_addr;
    end
`ifdef MEM_CTRL_LSB_PORT_EN
    if (in_lsb_ena) begin
      lsb_pend_next  = TRUE;
      lsb_rw_next    = in_lsb_rw;
      lsb_size_next  = in_lsb_size;
      lsb_addr_next  = in_lsb_addr;
      lsb_wdata_next = in_lsb_data;
    end
`endif
  end

  // Controller state register; ena low holds everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cyc_reg       <= '0;
      len_reg       <= '0;
      base_reg      <= '0;
      asm_reg       <= '0;
      if_pend_reg   <= FALSE;
      if_addr_reg   <= '0;
      if_ready_reg  <= FALSE;
      if_inst_reg   <= '0;
      prev_addr_reg <= '0;
    end else if (ena) begin
      state_reg     <= state_next;
      cyc_reg       <= cyc_next;
      len_reg       <= len_next;
      base_reg      <= base_next;
      asm_reg       <= asm_next;
      if_pend_reg   <= if_pend_next;
      if_addr_reg   <= if_addr_next;
      if_ready_reg  <= if_ready_next;
      if_inst_reg   <= if_inst_next;
      prev_addr_reg <= ram_addr_live;
    end
  end

`ifdef MEM_CTRL_LSB_PORT_EN
  // Load/store pending slot and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsb_pend_reg  <= FALSE;
      lsb_rw_reg    <= FALSE;
      lsb_size_reg  <= '0;
      lsb_addr_reg  <= '0;
      lsb_wdata_reg <= '0;
      wdata_reg     <= '0;
      lsb_ready_reg <= FALSE;
      lsb_data_reg  <= '0;
    end else if (ena) begin
      lsb_pend_reg  <= lsb_pend_next;
      lsb_rw_reg    <= lsb_rw_next;
      lsb_size_reg  <= lsb_size_next;
      lsb_addr_reg  <= lsb_addr_next;
      lsb_wdata_reg <= lsb_wdata_next;
      wdata_reg     <= wdata_next;
      lsb_ready_reg <= lsb_ready_next;
      lsb_data_reg  <= lsb_data_next;
    end
  end
`endif

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: none; widths come from shared constants (`DATA_WIDTH = 32-bit word).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ena  in  1  global run enable; low freezes all state and forces out_ram_rw=0.
REQ-005 in_flush  in  1  misprediction flush; aborts instruction traffic.
REQ-006 in_if_ena  in  1  fetcher request pulse; in_if_addr  in  32  fetch address.
REQ-007 out_if_ready  out  1  one-cycle pulse; out_if_inst  out  32  assembled little-endian word.
REQ-008 in_lsb_ena  in  1  data request pulse; in_lsb_rw  in  1  1=write; in_lsb_size  in  3  byte count (1, 2 or 4).
REQ-009 in_lsb_addr  in  32; in_lsb_data  in  32  store data, low bytes used.
REQ-010 out_lsb_ready  out  1  one-cycle pulse; out_lsb_data  out  32  load data, zero-extended.
REQ-011 out_ram_addr  out  32; out_ram_rw  out  1  1=write; out_ram_data  out  8; in_ram_data  in  8, valid one cycle after its address.

Function
REQ-012 Requests are single-cycle pulses; each SHALL be latched into a pending slot (one per port) and served later.
REQ-013 States: IDLE, IF_READ, LSB_READ, LSB_WRITE; IDLE selects pending LSB over pending IF.
REQ-014 Read of N bytes: address addr+k driven in the k-th busy cycle (k=0..N-1); byte k captured one cycle later into bits [8k+7:8k].
REQ-015 Read completes when the last byte is captured; ready pulses in the next cycle with data stable; IF read latency = 6 cycles from request edge to out_if_ready high.
REQ-016 Write: byte k of in_lsb_data driven with addr+k, out_ram_rw=1, one byte per cycle; out_lsb_ready pulses the cycle after the last byte.
REQ-017 Return to IDLE on the ready cycle; a pending request SHALL start on the following cycle.
REQ-018 New pulse on a port whose pending slot is already occupied: overwrite (requesters never do this; bench flags it).
REQ-019 in_flush: clears IF pending slot, aborts IF_READ to IDLE, suppresses that out_if_ready; LSB traffic unaffected.
REQ-020 Flush coincident with in_if_ena: the new request is kept (post-flush fetch).
REQ-021 Address increment wraps at 2^32.
REQ-022 Outside LSB_WRITE, out_ram_rw=0 and out_ram_data=0.

Reset
REQ-023 rst: state IDLE, pending slots cleared, all outputs 0, assembly buffer 0.
REQ-024 Reset mid-transfer: transfer discarded, no ready pulse.

Configuration
REQ-025 MEM_CTRL_LSB_PORT_EN defined: data port fully functional as above.
REQ-026 Undefined: LSB inputs ignored, out_lsb_ready/out_lsb_data tied 0, LSB states not built; IF behaviour unchanged.

Structure
REQ-027 State encoding, TRUE/FALSE, `DATA_WIDTH and RAM byte width live in constant.v.
REQ-028 Single module; no sub-module required.

Verification
REQ-029 IF read 0x00001000, RAM bytes 13 05 00 00 -> out_if_inst=0x00000513, ready pulse 6 cycles after request.
REQ-030 Store size 4, addr 0x20, data 0xDEADBEEF -> RAM writes EF,BE,AD,DE at 0x20..0x23, then out_lsb_ready.
REQ-031 IF and LSB load (size 2) pulsed same cycle -> load served first, zero-extended; IF ready follows.
REQ-032 Flush during IF_READ byte 2 -> no out_if_ready; next fetch to 0x2000 returns correct word.
REQ-033 rst asserted mid-store, ena low for 3 cycles mid-read -> no ready after reset; frozen read resumes and returns correct word.
